// File: rtl/alarm_snooze_ctrl_if.sv
// alarm_snooze_ctrl_if: user-side signals of the alarm annunciator
//   master: drives arm, match, snooze_n, stop_n; observes the annunciator outputs
//   slave : the annunciator itself
interface alarm_snooze_ctrl_if #(
    parameter int CW = 10
);
    logic          arm;
    logic          match;
    logic          snooze_n;
    logic          stop_n;
    logic          ring;
    logic          ringing;
    logic          snoozing;
    logic [1:0]    snooze_cnt;
    logic [CW-1:0] remaining;
    logic          missed;

    modport master (
        output arm, match, snooze_n, stop_n,
        input  ring, ringing, snoozing, snooze_cnt, remaining, missed
    );

    modport slave (
        input  arm, match, snooze_n, stop_n,
        output ring, ringing, snoozing, snooze_cnt, remaining, missed
    );
endinterface

// File: rtl/alarm_snooze_ctrl.sv
// alarm_snooze_ctrl: alarm annunciator with 1 Hz blink, bounded snooze, stop, auto-timeout and missed flag
//   CLK_2Hz : 2 Hz tick clock
//   reset   : asynchronous active-high reset
//   bus     : arm/match/buttons in; ring, ringing, snoozing, snooze_cnt, remaining, missed out
module alarm_snooze_ctrl #(
    parameter int RING_TICKS   = 120,
    parameter int SNOOZE_TICKS = 600,
    parameter int MAX_SNOOZES  = 3,
    parameter int CW           = 10
) (
    input  logic                CLK_2Hz,
    input  logic                reset,
    alarm_snooze_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RINGING  = 2'b01,
        SNOOZE   = 2'b10,
        WAIT_CLR = 2'b11
    } state_t;

    localparam logic [CW-1:0] RING_LD   = CW'(RING_TICKS - 1);
    localparam logic [CW-1:0] SNOOZE_LD = CW'(SNOOZE_TICKS - 1);
    localparam logic [1:0]    MAX_CNT   = 2'(MAX_SNOOZES);

    state_t        state_q, state_d;
    logic [2:0]    snz_sync_q, snz_sync_d;
    logic [2:0]    stp_sync_q, stp_sync_d;
    logic          match_q, match_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          ring_q, ring_d;
    logic          ringing_q, ringing_d;
    logic          snoozing_q, snoozing_d;
    logic          missed_q, missed_d;
    logic          snooze_press, stop_press, match_rise;

    always_comb begin
        // two sync stages, third stage holds the previous synced value for edge detect
        snz_sync_d   = {snz_sync_q[1:0], bus.snooze_n};
        stp_sync_d   = {stp_sync_q[1:0], bus.stop_n};
        snooze_press = snz_sync_q[2] & ~snz_sync_q[1];
        stop_press   = stp_sync_q[2] & ~stp_sync_q[1];
        match_d      = bus.match;
        match_rise   = bus.match & ~match_q;
        state_d      = state_q;
        timer_d      = timer_q;
        cnt_d        = cnt_q;
        ring_d       = 1'b0;
        missed_d     = stop_press ? 1'b0 : missed_q;
        case (state_q)
            IDLE: begin
                if (bus.arm && match_rise) begin
                    state_d = RINGING;
                    timer_d = RING_LD;
                    cnt_d   = '0;
                    ring_d  = 1'b1;
                end
            end
            RINGING: begin
                if (!bus.arm || stop_press) begin
                    state_d = WAIT_CLR;
                    timer_d = '0;
                end else if (snooze_press && cnt_q < MAX_CNT) begin
                    state_d = SNOOZE;
                    timer_d = SNOOZE_LD;
                    cnt_d   = cnt_q + 2'd1;
                end else if (timer_q == '0) begin
                    state_d  = WAIT_CLR;
                    missed_d = 1'b1;
                end else begin
                    timer_d = timer_q - CW'(1);
                    ring_d  = ~ring_q;
                end
            end
            SNOOZE: begin
                if (!bus.arm || stop_press) begin
                    state_d = WAIT_CLR;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    state_d = RINGING;
                    timer_d = RING_LD;
                    ring_d  = 1'b1;
                end else begin
                    timer_d = timer_q - CW'(1);
                end
            end
            WAIT_CLR: begin
                // hold off re-trigger until the matching second has passed
                if (!bus.match) state_d = IDLE;
            end
        endcase
        ringing_d  = state_d == RINGING;
        snoozing_d = state_d == SNOOZE;
    end

    always_ff @(posedge CLK_2Hz or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            snz_sync_q <= '1;
            stp_sync_q <= '1;
            match_q    <= 1'b0;
            timer_q    <= '0;
            cnt_q      <= '0;
            ring_q     <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            missed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            snz_sync_q <= snz_sync_d;
            stp_sync_q <= stp_sync_d;
            match_q    <= match_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            ring_q     <= ring_d;
            ringing_q  <= ringing_d;
            snoozing_q <= snoozing_d;
            missed_q   <= missed_d;
        end
    end

    assign bus.ring       = ring_q;
    assign bus.ringing    = ringing_q;
    assign bus.snoozing   = snoozing_q;
    assign bus.snooze_cnt = cnt_q;
    assign bus.remaining  = timer_q;
    assign bus.missed     = missed_q;
endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// tb_alarm_snooze_ctrl: directed checks of the alarm annunciator with short timers
module tb_alarm_snooze_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alarm_snooze_ctrl_if #(.CW(4)) bus ();

    alarm_snooze_ctrl #(
        .RING_TICKS(4), .SNOOZE_TICKS(6), .MAX_SNOOZES(2), .CW(4)
    ) dut (
        .CLK_2Hz(clk),
        .reset(rst),
        .bus(bus)
    );

    // packed view: {ringing, snoozing, snooze_cnt, remaining, missed, ring}
    function automatic logic [9:0] e(input logic rg, input logic sz, input logic [1:0] c,
                                     input logic [3:0] r, input logic m, input logic rn);
        return {rg, sz, c, r, m, rn};
    endfunction

    function automatic logic [9:0] obs();
        return {bus.ringing, bus.snoozing, bus.snooze_cnt, bus.remaining, bus.missed, bus.ring};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.arm = 1'b0; bus.match = 1'b0; bus.snooze_n = 1'b1; bus.stop_n = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // one-cycle press; its effect is visible after the third tick
    task automatic press(input logic s, input logic p);
        bus.snooze_n = ~s; bus.stop_n = ~p;
        tick();
        bus.snooze_n = 1'b1; bus.stop_n = 1'b1;
        tick();
        tick();
    endtask

    // match high for two edges; returns one edge after the rise (remaining=2, ring=0)
    task automatic start_ring();
        bus.match = 1'b1;
        tick();
        tick();
        bus.match = 1'b0;
    endtask

    task automatic test_reset();
        bus.arm = 1'b0; bus.match = 1'b0; bus.snooze_n = 1'b1; bus.stop_n = 1'b1;
        rst = 1'b1;
        tick();
        n_cmp++;
        if (obs() !== e(0,0,0,0,0,0)) begin n_bad++; $display("FAIL reset_held got %b want %b", obs(), e(0,0,0,0,0,0)); end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (obs() !== e(0,0,0,0,0,0)) begin n_bad++; $display("FAIL reset_released got %b want %b", obs(), e(0,0,0,0,0,0)); end
    endtask

    task automatic test_timeout();
        logic [9:0] w [8];
        w = '{e(0,0,0,0,0,0), e(0,0,0,0,0,0), e(1,0,0,3,0,1), e(1,0,0,2,0,0),
              e(1,0,0,1,0,1), e(1,0,0,0,0,0), e(0,0,0,0,1,0), e(0,0,0,0,1,0)};
        do_reset();
        bus.arm = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.match = (i == 2 || i == 3);
            tick();
            n_cmp++;
            if (obs() !== w[i]) begin n_bad++; $display("FAIL timeout_edge%0d got %b want %b", i + 1, obs(), w[i]); end
        end
        press(1'b0, 1'b1);
        n_cmp++;
        if (obs() !== e(0,0,0,0,0,0)) begin n_bad++; $display("FAIL stop_idle_clears_missed got %b want %b", obs(), e(0,0,0,0,0,0)); end
    endtask

    task automatic test_snooze();
        logic [9:0] w [11];
        w = '{e(1,0,0,3,0,1), e(1,0,0,2,0,0), e(1,0,0,1,0,1), e(0,1,1,5,0,0),
              e(0,1,1,4,0,0), e(0,1,1,3,0,0), e(0,1,1,2,0,0), e(0,1,1,1,0,0),
              e(0,1,1,0,0,0), e(1,0,1,3,0,1), e(1,0,1,2,0,0)};
        do_reset();
        bus.arm = 1'b1;
        for (int i = 0; i < 11; i++) begin
            bus.match = (i <= 1);
            bus.snooze_n = !(i >= 1 && i <= 5);
            tick();
            n_cmp++;
            if (obs() !== w[i]) begin n_bad++; $display("FAIL snooze_e%0d got %b want %b", i, obs(), w[i]); end
        end
        bus.snooze_n = 1'b1;
    endtask

    task automatic test_max_snooze();
        do_reset();
        bus.arm = 1'b1;
        start_ring();
        n_cmp++;
        if (obs() !== e(1,0,0,2,0,0)) begin n_bad++; $display("FAIL max_start got %b want %b", obs(), e(1,0,0,2,0,0)); end
        press(1'b1, 1'b0);
        n_cmp++;
        if (obs() !== e(0,1,1,5,0,0)) begin n_bad++; $display("FAIL max_snooze1 got %b want %b", obs(), e(0,1,1,5,0,0)); end
        press(1'b1, 1'b0);
        n_cmp++;
        if (obs() !== e(0,1,1,2,0,0)) begin n_bad++; $display("FAIL max_press_in_snooze got %b want %b", obs(), e(0,1,1,2,0,0)); end
        repeat (3) tick();
        n_cmp++;
        if (obs() !== e(1,0,1,3,0,1)) begin n_bad++; $display("FAIL max_rering1 got %b want %b", obs(), e(1,0,1,3,0,1)); end
        press(1'b1, 1'b0);
        n_cmp++;
        if (obs() !== e(0,1,2,5,0,0)) begin n_bad++; $display("FAIL max_snooze2 got %b want %b", obs(), e(0,1,2,5,0,0)); end
        repeat (6) tick();
        n_cmp++;
        if (obs() !== e(1,0,2,3,0,1)) begin n_bad++; $display("FAIL max_rering2 got %b want %b", obs(), e(1,0,2,3,0,1)); end
        press(1'b1, 1'b0);
        n_cmp++;
        if (obs() !== e(1,0,2,0,0,0)) begin n_bad++; $display("FAIL max_third_ignored got %b want %b", obs(), e(1,0,2,0,0,0)); end
        tick();
        n_cmp++;
        if (obs() !== e(0,0,2,0,1,0)) begin n_bad++; $display("FAIL max_timeout got %b want %b", obs(), e(0,0,2,0,1,0)); end
        tick();
    endtask

    task automatic test_snooze_stop_same_edge();
        start_ring();
        n_cmp++;
        if (obs() !== e(1,0,0,2,1,0)) begin n_bad++; $display("FAIL both_new_event got %b want %b", obs(), e(1,0,0,2,1,0)); end
        press(1'b1, 1'b0);
        n_cmp++;
        if (obs() !== e(0,1,1,5,1,0)) begin n_bad++; $display("FAIL both_snooze got %b want %b", obs(), e(0,1,1,5,1,0)); end
        repeat (6) tick();
        n_cmp++;
        if (obs() !== e(1,0,1,3,1,1)) begin n_bad++; $display("FAIL both_rering got %b want %b", obs(), e(1,0,1,3,1,1)); end
        press(1'b1, 1'b1);
        n_cmp++;
        if (obs() !== e(0,0,1,0,0,0)) begin n_bad++; $display("FAIL both_stop_wins got %b want %b", obs(), e(0,0,1,0,0,0)); end
    endtask

    task automatic test_disarm_in_snooze();
        do_reset();
        bus.arm = 1'b1;
        start_ring();
        press(1'b1, 1'b0);
        n_cmp++;
        if (obs() !== e(0,1,1,5,0,0)) begin n_bad++; $display("FAIL disarm_snooze got %b want %b", obs(), e(0,1,1,5,0,0)); end
        bus.arm = 1'b0;
        bus.match = 1'b1;
        tick();
        n_cmp++;
        if (obs() !== e(0,0,1,0,0,0)) begin n_bad++; $display("FAIL disarm_wait_clr got %b want %b", obs(), e(0,0,1,0,0,0)); end
        bus.arm = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs() !== e(0,0,1,0,0,0)) begin n_bad++; $display("FAIL disarm_hold%0d got %b want %b", i, obs(), e(0,0,1,0,0,0)); end
        end
        bus.match = 1'b0;
        tick();
        bus.match = 1'b1;
        tick();
        n_cmp++;
        if (obs() !== e(1,0,0,3,0,1)) begin n_bad++; $display("FAIL disarm_retrigger got %b want %b", obs(), e(1,0,0,3,0,1)); end
        bus.match = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.arm = 1'b1;
        start_ring();
        tick();
        n_cmp++;
        if (obs() !== e(1,0,0,1,0,1)) begin n_bad++; $display("FAIL areset_pre got %b want %b", obs(), e(1,0,0,1,0,1)); end
        bus.snooze_n = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== e(0,0,0,0,0,0)) begin n_bad++; $display("FAIL areset_immediate got %b want %b", obs(), e(0,0,0,0,0,0)); end
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (obs() !== e(0,0,0,0,0,0)) begin n_bad++; $display("FAIL areset_held_button got %b want %b", obs(), e(0,0,0,0,0,0)); end
        bus.snooze_n = 1'b1;
        tick();
        start_ring();
        n_cmp++;
        if (obs() !== e(1,0,0,2,0,0)) begin n_bad++; $display("FAIL areset_fresh_event got %b want %b", obs(), e(1,0,0,2,0,0)); end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_snooze();
        test_max_snooze();
        test_snooze_stop_same_edge();
        test_disarm_in_snooze();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
